// File: rtl/litton_drum_pkg.sv
// litton_drum_pkg: shared drum track geometry, timing-track mark positions and seek states.
package litton_drum_pkg;
  localparam int WORD_BITS   = 40;
  localparam int TRACK_WORDS = 128;
  localparam int TRACK_BITS  = WORD_BITS * TRACK_WORDS;
  localparam logic [5:0] Z2_A_LO    = 6'd31;
  localparam logic [5:0] Z2_A_HI    = 6'd33;
  localparam logic [5:0] Z2_B_LO    = 6'd38;
  localparam logic [5:0] Z2_B_HI    = 6'd39;
  localparam logic [5:0] ADDR_START = 6'd32;
  typedef enum logic {SEEK_IDLE, SEEK_WAIT} seek_state_t;
  function automatic logic z2_at(input logic [5:0] b);
    return (b >= Z2_A_LO && b <= Z2_A_HI) || (b >= Z2_B_LO && b <= Z2_B_HI);
  endfunction
  // Z3 carries the following word's address LSB first, then an index mark before word 0.
  function automatic logic z3_at(input logic [5:0] b, input logic [6:0] w);
    logic [6:0] nxt;
    logic [5:0] off;
    nxt = w + 7'd1;
    off = b - ADDR_START;
    return (b >= ADDR_START && b < ADDR_START + 6'd7) ? nxt[off[2:0]] :
           (b == 6'(WORD_BITS - 1)) && (nxt == 7'd0);
  endfunction
endpackage

// File: rtl/drum_seek_fsm.sv
// drum_seek_fsm: captures a target word and pulses ack when the drum reaches its bit 0.
module drum_seek_fsm
  import litton_drum_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [6:0] tgt,
  input  logic       at_mark,
  input  logic [6:0] word,
  output logic       busy,
  output logic       ack
);
  seek_state_t state;
  logic [6:0] tgt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEEK_IDLE;
      tgt_q <= '0;
      busy  <= 1'b0;
      ack   <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (state == SEEK_IDLE && req && !ack) begin
        state <= SEEK_WAIT;
        tgt_q <= tgt;
        busy  <= 1'b1;
      end else if (state == SEEK_WAIT && at_mark && word == tgt_q) begin
        state <= SEEK_IDLE;
        busy  <= 1'b0;
        ack   <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/drum_timing_gen.sv
// drum_timing_gen: drum bit/word counters, Z1/Z2/Z3 timing tracks and seek control.
module drum_timing_gen
  import litton_drum_pkg::*;
#(
  parameter int DIV   = 10,
  parameter int Z1_HI = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RUN,
  input  logic        REQ,
  input  logic [6:0]  TGT,
  output logic        Z1,
  output logic        Z2,
  output logic        Z3,
  output logic [12:0] BIT,
  output logic [5:0]  BITW,
  output logic [6:0]  WORD,
  output logic        BUSY,
  output logic        ACK
);
  localparam int PW = $clog2(DIV);
  logic [PW-1:0] phase, phase_n;
  logic [5:0] bitw_n;
  logic [6:0] word_n;
  logic [12:0] bit_n;
  logic live, step, bit_end, word_end, at_mark;
  // The first running edge after reset presents phase 0 rather than advancing past it.
  always_comb begin
    step     = RUN && live;
    bit_end  = step && phase == PW'(DIV - 1);
    word_end = bit_end && BITW == 6'(WORD_BITS - 1);
    phase_n  = bit_end ? '0 : step ? phase + PW'(1) : phase;
    bitw_n   = word_end ? '0 : bit_end ? BITW + 6'd1 : BITW;
    word_n   = word_end ? WORD + 7'd1 : WORD;
    bit_n    = bit_end ? (BIT == 13'(TRACK_BITS - 1) ? '0 : BIT + 13'd1) : BIT;
    at_mark  = RUN && phase_n == '0 && bitw_n == '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      live  <= 1'b0;
      phase <= '0;
      BITW  <= '0;
      WORD  <= '0;
      BIT   <= '0;
      Z1    <= 1'b0;
      Z2    <= 1'b0;
      Z3    <= 1'b0;
    end else begin
      live  <= live | RUN;
      phase <= phase_n;
      BITW  <= bitw_n;
      WORD  <= word_n;
      BIT   <= bit_n;
      Z1    <= RUN && int'(phase_n) < Z1_HI;
      Z2    <= z2_at(bitw_n);
      Z3    <= z3_at(bitw_n, word_n);
    end
  end
  drum_seek_fsm u_seek (
    .clk    (CLK),
    .rst    (RST),
    .req    (REQ),
    .tgt    (TGT),
    .at_mark(at_mark),
    .word   (word_n),
    .busy   (BUSY),
    .ack    (ACK)
  );
endmodule
